// File: rtl/fsb_if.sv
// CPU-side bus bundle for the fast-bus cycle controller.
// The master drives the CPU strobes, decodes and acks; the slave (controller) drives the terminations and status.
interface fsb_if #(
    parameter int NCH = 4,
    parameter int WSW = 3
);
    logic               nAS;
    logic [NCH-1:0]     CS;
    logic [NCH*WSW-1:0] WS;
    logic               IACS;
    logic [NCH-1:0]     ExtRdy;
    logic               nBERRExt;
    logic               RefAck;
    logic               nDTACK;
    logic               nVPA;
    logic               nBERR;
    logic               ASActive;
    logic               ASInactive;
    logic               RefReq;
    logic               RefUrgent;
    logic               RefOverrun;

    modport master (
        output nAS, CS, WS, IACS, ExtRdy, nBERRExt, RefAck,
        input  nDTACK, nVPA, nBERR, ASActive, ASInactive, RefReq, RefUrgent, RefOverrun
    );

    modport slave (
        input  nAS, CS, WS, IACS, ExtRdy, nBERRExt, RefAck,
        output nDTACK, nVPA, nBERR, ASActive, ASInactive, RefReq, RefUrgent, RefOverrun
    );
endinterface

// File: rtl/fsb_ctrl.sv
// Fast-bus cycle controller: terminates 68000 bus cycles with nDTACK/nVPA/nBERR per chip-select channel,
// with a bus-timeout watchdog and a refresh scheduler that accumulates debt.
module fsb_ctrl #(
    parameter int             NCH       = 4,
    parameter int             WSW       = 3,
    parameter logic [NCH-1:0] EXTMASK   = 4'b1000,
    parameter int             REF_DIV   = 256,
    parameter int             REF_URG   = 128,
    parameter int             MAXDEBT   = 3,
    parameter int             TO_CYCLES = 200
) (
    input logic  FCLK,
    input logic  nRES,
    fsb_if.slave bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TOW = $clog2(TO_CYCLES);
    localparam int RCW = $clog2(REF_DIV);
    localparam int DW  = $clog2(MAXDEBT + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_EXTW = 3'd2;
    localparam logic [2:0] S_ACK  = 3'd3;
    localparam logic [2:0] S_VPA  = 3'd4;
    localparam logic [2:0] S_BERR = 3'd5;

    logic [2:0]     state, state_nx;
    logic [CHW-1:0] ch, ch_nx, ch_sel;
    logic [WSW-1:0] wcnt, wcnt_nx, ws_sel;
    logic [WSW-1:0] ws_arr [NCH];
    logic [TOW-1:0] to_cnt, to_inc;
    logic           nosel, nosel_nx;
    logic           any_cs, timeout;
    logic           as_q, as_active, as_inactive;
    logic [RCW-1:0] ref_cnt;
    logic [DW-1:0]  debt;
    logic           ref_wrap, ack_eff, overrun;

    assign as_active   = ~bus.nAS;
    assign as_inactive = bus.nAS & as_q;

    // Lowest-index asserted chip select wins
    always_comb begin
        ch_sel = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.CS[i]) ch_sel = CHW'(i);
        end
        for (int i = 0; i < NCH; i++) begin
            ws_arr[i] = bus.WS[i*WSW +: WSW];
        end
    end

    assign any_cs  = |bus.CS;
    assign ws_sel  = ws_arr[ch_sel];
    assign to_inc  = to_cnt + 1'b1;
    assign timeout = (to_inc == TOW'(TO_CYCLES - 1));

    always_comb begin
        state_nx = state;
        ch_nx    = ch;
        wcnt_nx  = wcnt;
        nosel_nx = nosel;
        case (state)
            S_IDLE: begin
                if (as_active) begin
                    ch_nx    = ch_sel;
                    wcnt_nx  = ws_sel;
                    nosel_nx = ~any_cs & ~bus.IACS;
                    if (bus.IACS)                               state_nx = S_VPA;
                    else if (!any_cs)                           state_nx = S_WAIT;
                    else if (ws_sel == '0 && EXTMASK[ch_sel])   state_nx = S_EXTW;
                    else                                        state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                // An abandoned cycle (strobe released before termination) drops straight back to idle
                if (as_inactive)  state_nx = S_IDLE;
                else if (timeout) state_nx = S_BERR;
                else if (!nosel) begin
                    if (wcnt != '0) wcnt_nx  = wcnt - 1'b1;
                    else            state_nx = EXTMASK[ch] ? S_EXTW : S_ACK;
                end
            end
            S_EXTW: begin
                if (as_inactive)        state_nx = S_IDLE;
                else if (timeout)       state_nx = S_BERR;
                else if (!bus.nBERRExt) state_nx = S_BERR;
                else if (bus.ExtRdy[ch]) state_nx = S_ACK;
            end
            S_ACK, S_VPA, S_BERR: begin
                if (as_inactive) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // nVPA trails entry to VPA by one edge; nDTACK/nBERR follow the state entered on this edge
    always_ff @(posedge FCLK) begin
        if (!nRES) begin
            state      <= S_IDLE;
            ch         <= '0;
            wcnt       <= '0;
            nosel      <= 1'b0;
            to_cnt     <= '0;
            as_q       <= 1'b0;
            bus.nDTACK <= 1'b1;
            bus.nVPA   <= 1'b1;
            bus.nBERR  <= 1'b1;
        end else begin
            state      <= state_nx;
            ch         <= ch_nx;
            wcnt       <= wcnt_nx;
            nosel      <= nosel_nx;
            as_q       <= as_active;
            if (state == S_WAIT || state == S_EXTW) to_cnt <= to_inc;
            else if (state == S_IDLE)               to_cnt <= '0;
            bus.nDTACK <= ~(state_nx == S_ACK);
            bus.nVPA   <= ~(state == S_VPA && state_nx == S_VPA);
            bus.nBERR  <= ~(state_nx == S_BERR);
        end
    end

    assign ref_wrap = (ref_cnt == RCW'(REF_DIV - 1));
    assign ack_eff  = bus.RefAck & (debt != '0);

    // A wrap and a completed refresh on the same edge cancel out
    always_ff @(posedge FCLK) begin
        if (!nRES) begin
            ref_cnt <= '0;
            debt    <= '0;
            overrun <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
            if (ref_wrap && !ack_eff) begin
                if (debt == DW'(MAXDEBT)) overrun <= 1'b1;
                else                      debt    <= debt + 1'b1;
            end else if (!ref_wrap && ack_eff) begin
                debt <= debt - 1'b1;
            end
        end
    end

    assign bus.ASActive   = as_active;
    assign bus.ASInactive = as_inactive;
    assign bus.RefReq     = (debt != '0);
    assign bus.RefUrgent  = (debt >= DW'(2)) || (debt == DW'(1) && ref_cnt >= RCW'(REF_URG));
    assign bus.RefOverrun = overrun;
endmodule

// File: tb/tb_fsb_ctrl.sv
// Scoreboard bench for fsb_ctrl: stimulus queues timed expectations, a negedge monitor pops and compares them.
module tb_fsb_ctrl;
    localparam logic [5:0] M_ALL = 6'b111111;
    localparam logic [5:0] M_STB = 6'b111000;
    localparam logic [5:0] M_REF = 6'b000111;

    typedef struct {
        int         c;
        string      nm;
        logic [5:0] mask;
        logic [5:0] val;
    } exp_t;

    logic FCLK = 1'b0;
    logic nRES;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   viol = 0;
    int   rd = 0;
    logic done = 1'b0;
    exp_t sb[$];
    logic [5:0] obs;

    fsb_if #(.NCH(4), .WSW(3)) bus();

    fsb_ctrl dut (
        .FCLK (FCLK),
        .nRES (nRES),
        .bus  (bus.slave)
    );

    always #5 FCLK = ~FCLK;

    always @(posedge FCLK) cyc <= cyc + 1;

    assign obs = {bus.nDTACK, bus.nVPA, bus.nBERR, bus.RefReq, bus.RefUrgent, bus.RefOverrun};

    task automatic expect_at(input int c, input string nm, input logic [5:0] m, input logic [5:0] v);
        exp_t e;
        int   k;
        e.c = c; e.nm = nm; e.mask = m; e.val = v;
        k = sb.size();
        while (k > rd && sb[k-1].c > c) k--;
        sb.insert(k, e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge FCLK);
    endtask

    always @(negedge FCLK) begin
        if ((int'(!bus.nDTACK) + int'(!bus.nVPA) + int'(!bus.nBERR)) > 1) viol = viol + 1;
        while (rd < sb.size() && sb[rd].c <= cyc) begin
            checks = checks + 1;
            if (sb[rd].c < cyc)
                $display("FAIL %s: never sampled at cycle %0d (now %0d)", sb[rd].nm, sb[rd].c, cyc);
            else if ((obs & sb[rd].mask) !== sb[rd].val)
                $display("FAIL %s: got %b, required %b (mask %b) at cycle %0d",
                         sb[rd].nm, obs & sb[rd].mask, sb[rd].val, sb[rd].mask, cyc);
            else
                passes = passes + 1;
            rd = rd + 1;
        end
        if (done) begin
            done = 1'b0;
            checks = checks + 1;
            if (viol == 0) passes = passes + 1;
            else $display("FAIL strobe_exclusive: %0d cycles with more than one strobe low, required 0", viol);
            checks = checks + 1;
            if (rd == sb.size()) passes = passes + 1;
            else $display("FAIL pending_expect: %0d expectations unchecked, required 0", sb.size() - rd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r, r2;
        nRES = 1'b0;
        bus.nAS = 1'b1; bus.CS = '0; bus.WS = '0; bus.IACS = 1'b0;
        bus.ExtRdy = '0; bus.nBERRExt = 1'b1; bus.RefAck = 1'b0;

        // Reset, then idle refresh accumulation
        @(negedge FCLK);
        n = cyc;
        expect_at(n + 2, "reset_state", M_ALL, 6'b111000);
        wait_to(n + 3);
        r = cyc;
        nRES = 1'b1;
        expect_at(r + 1,   "idle_after_reset", M_ALL, 6'b111000);
        expect_at(r + 10,  "idle_10",          M_ALL, 6'b111000);
        expect_at(r + 255, "refreq_before",    M_REF, 6'b000000);
        expect_at(r + 256, "refreq_at_wrap",   M_REF, 6'b000100);
        expect_at(r + 383, "urgent_before",    M_REF, 6'b000100);
        expect_at(r + 384, "urgent_at_128",    M_REF, 6'b000110);
        expect_at(r + 391, "refack_clears",    M_REF, 6'b000000);
        wait_to(r + 390);
        bus.RefAck = 1'b1;
        wait_to(r + 391);
        bus.RefAck = 1'b0;

        // Channel 1, three wait states; nBERRExt must be ignored on a non-external channel
        wait_to(r + 395);
        n = cyc;
        bus.nAS = 1'b0; bus.CS = 4'b0010; bus.WS = 12'b000_000_011_000; bus.nBERRExt = 1'b0;
        expect_at(n + 4, "ws3_not_yet",   M_STB, 6'b111000);
        expect_at(n + 5, "ws3_dtack",     M_STB, 6'b011000);
        expect_at(n + 8, "ws3_hold",      M_STB, 6'b011000);
        expect_at(n + 9, "ws3_release",   M_STB, 6'b111000);
        wait_to(n + 8);
        bus.nAS = 1'b1; bus.CS = '0; bus.nBERRExt = 1'b1;

        // External-ready channel 3, ready arrives after five low cycles
        wait_to(n + 11);
        n = cyc;
        bus.nAS = 1'b0; bus.CS = 4'b1000; bus.WS = '0; bus.ExtRdy = '0;
        expect_at(n + 5, "ext_waiting",   M_STB, 6'b111000);
        expect_at(n + 6, "ext_dtack",     M_STB, 6'b011000);
        expect_at(n + 8, "ext_hold",      M_STB, 6'b011000);
        expect_at(n + 9, "ext_release",   M_STB, 6'b111000);
        wait_to(n + 5);
        bus.ExtRdy = 4'b1000;
        wait_to(n + 8);
        bus.nAS = 1'b1; bus.CS = '0; bus.ExtRdy = '0;

        // External BERR and ready sampled together: BERR wins
        wait_to(n + 11);
        n = cyc;
        bus.nAS = 1'b0; bus.CS = 4'b1000;
        expect_at(n + 3, "extberr_wait",  M_STB, 6'b111000);
        expect_at(n + 4, "extberr_berr",  M_STB, 6'b110000);
        expect_at(n + 6, "extberr_hold",  M_STB, 6'b110000);
        expect_at(n + 8, "extberr_rel",   M_STB, 6'b111000);
        wait_to(n + 3);
        bus.ExtRdy = 4'b1000; bus.nBERRExt = 1'b0;
        wait_to(n + 7);
        bus.nAS = 1'b1; bus.CS = '0; bus.ExtRdy = '0; bus.nBERRExt = 1'b1;

        // No chip select: cycle ends by timeout
        wait_to(n + 10);
        n = cyc;
        bus.nAS = 1'b0; bus.CS = '0;
        expect_at(n + 199, "timeout_before", M_STB, 6'b111000);
        expect_at(n + 200, "timeout_berr",   M_STB, 6'b110000);
        expect_at(n + 202, "timeout_hold",   M_STB, 6'b110000);
        expect_at(n + 204, "timeout_rel",    M_STB, 6'b111000);
        wait_to(n + 203);
        bus.nAS = 1'b1;

        // Interrupt acknowledge overrides CS
        wait_to(n + 206);
        n = cyc;
        bus.nAS = 1'b0; bus.CS = 4'b0001; bus.IACS = 1'b1;
        expect_at(n + 1, "iack_first",   M_STB, 6'b111000);
        expect_at(n + 2, "iack_vpa",     M_STB, 6'b101000);
        expect_at(n + 4, "iack_hold",    M_STB, 6'b101000);
        expect_at(n + 6, "iack_release", M_STB, 6'b111000);
        wait_to(n + 5);
        bus.nAS = 1'b1; bus.CS = '0; bus.IACS = 1'b0;

        // Two chip selects: channel 0 (zero waits) beats channel 2 (five waits)
        wait_to(n + 8);
        n = cyc;
        bus.nAS = 1'b0; bus.CS = 4'b0101; bus.WS = 12'b000_101_000_000;
        expect_at(n + 1, "prio_first",   M_STB, 6'b111000);
        expect_at(n + 2, "prio_ch0",     M_STB, 6'b011000);
        expect_at(n + 4, "prio_release", M_STB, 6'b111000);
        wait_to(n + 3);
        bus.nAS = 1'b1; bus.CS = '0;

        // Fresh reset, then refresh debt saturation and overrun
        wait_to(n + 6);
        nRES = 1'b0;
        wait_to(n + 9);
        r2 = cyc;
        nRES = 1'b1;
        expect_at(r2 + 768,  "debt3",           M_REF, 6'b000110);
        expect_at(r2 + 1023, "no_overrun_yet",  M_REF, 6'b000110);
        expect_at(r2 + 1024, "overrun",         M_REF, 6'b000111);
        expect_at(r2 + 1280, "wrap_and_ack",    M_REF, 6'b000111);
        expect_at(r2 + 1293, "debt1_after_2ack", M_REF, 6'b000101);
        expect_at(r2 + 1295, "debt0",           M_REF, 6'b000001);
        expect_at(r2 + 1300, "ack_at_zero_ign", M_REF, 6'b000001);
        wait_to(r2 + 1279);
        bus.RefAck = 1'b1;
        wait_to(r2 + 1280);
        bus.RefAck = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_to(r2 + 1290 + 2 * k);
            bus.RefAck = 1'b1;
            wait_to(r2 + 1291 + 2 * k);
            bus.RefAck = 1'b0;
        end

        // Reset asserted while nDTACK is low releases everything on that edge
        wait_to(r2 + 1302);
        n = cyc;
        bus.nAS = 1'b0; bus.CS = 4'b0001; bus.WS = '0;
        expect_at(n + 2, "pre_reset_ack",  M_STB, 6'b011000);
        expect_at(n + 5, "midcycle_reset", M_ALL, 6'b111000);
        expect_at(n + 7, "reset_hold",     M_ALL, 6'b111000);
        wait_to(n + 4);
        nRES = 1'b0;
        wait_to(n + 7);
        bus.nAS = 1'b1; bus.CS = '0;
        wait_to(n + 8);
        nRES = 1'b1;
        wait_to(n + 12);

        done = 1'b1;
        repeat (3) @(negedge FCLK);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
